// File: rtl/cpu_prog_loader_pkg.sv
// Shared definitions for the CPU program loader: opcode default,
// FSM state encoding, terminate word and on/off levels.
package cpu_prog_loader_pkg;

  // Must equal the CPU's LD_INS opcode.
  localparam logic [3:0] LD_OPC_DEF = 4'hE;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Terminate word is all ones; sliced to the io_inst width at use.
  localparam logic [63:0] TERM_WORD = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SEL,
    DATA,
    TERM,
    REL,
    DONE
  } state_t;

endpackage

// File: rtl/cpu_prog_loader_if.sv
// Program-source stream and CPU load bus seen by the loader.
// master: the loader side; slave: the source/CPU side.
interface cpu_prog_loader_if #(
  parameter int BIT_INST = 16,
  parameter int BIT_DATA = 16
);
  logic                src_valid;
  logic [BIT_DATA-1:0] src_data;
  logic                src_ready;
  logic                interrupt;
  logic [BIT_INST-1:0] io_inst;
  logic [BIT_DATA-1:0] io_din;

  modport master (
    input  src_valid, src_data,
    output src_ready, interrupt, io_inst, io_din
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready, interrupt, io_inst, io_din
  );
endinterface

// File: rtl/cpu_prog_loader_phase_timer.sv
// Loadable down-counter timing each bus phase. Loading sets HOLD-1 so
// that expired rises in the HOLD-th cycle after the load.
module phase_timer #(
  parameter int HOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/cpu_prog_loader.sv
// Autonomous loader that writes a program into the CPU instruction
// store through the interrupt / io_inst / io_din load protocol.
module cpu_prog_loader
  import cpu_prog_loader_pkg::*;
#(
  parameter int BIT_INST              = 16,
  parameter int BIT_DATA              = 16,
  parameter int SZA_INS               = 16,
  parameter int OPC_W                 = 4,
  parameter logic [OPC_W-1:0] LD_OPC  = OPC_W'(LD_OPC_DEF),
  parameter int HOLD                  = 4,
  parameter int AFW                   = $clog2(SZA_INS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [AFW-1:0]   base_addr,
  input  logic [AFW:0]     word_cnt,
  cpu_prog_loader_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AFW:0]     loaded
);

  localparam logic [AFW+1:0] DEPTH = (AFW + 2)'(SZA_INS);

  state_t              state_q, state_d;
  logic [AFW-1:0]      addr_q, addr_d;
  logic [AFW:0]        cnt_q, cnt_d;
  logic [AFW:0]        loaded_q, loaded_d;
  logic                aborted_q, aborted_d;
  logic                interrupt_q, interrupt_d;
  logic                src_ready_q, src_ready_d;
  logic [BIT_INST-1:0] io_inst_q, io_inst_d;
  logic [BIT_DATA-1:0] io_din_q, io_din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                expired;
  logic [AFW+1:0]      span;
  logic                range_ok;

  function automatic logic [BIT_INST-1:0] load_cmd(input logic [AFW-1:0] a);
    logic [BIT_INST-1:0] c;
    c = '0;
    c[BIT_INST-1 -: OPC_W]       = LD_OPC;
    c[BIT_INST-OPC_W-1 -: AFW]   = a;
    return c;
  endfunction

  assign span     = {2'b00, base_addr} + {1'b0, word_cnt};
  assign range_ok = (word_cnt != '0) && (span <= DEPTH);

  phase_timer #(.HOLD(HOLD)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (state_d != state_q),
    .expired (expired)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      loaded_q    <= '0;
      aborted_q   <= OFF;
      interrupt_q <= OFF;
      src_ready_q <= OFF;
      io_inst_q   <= '0;
      io_din_q    <= '0;
      busy_q      <= OFF;
      done_q      <= OFF;
      err_q       <= OFF;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      aborted_q   <= aborted_d;
      interrupt_q <= interrupt_d;
      src_ready_q <= src_ready_d;
      io_inst_q   <= io_inst_d;
      io_din_q    <= io_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next state and next output values; abort is only looked at when the
  // current phase timer has expired.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    loaded_d    = loaded_q;
    aborted_d   = aborted_q;
    interrupt_d = interrupt_q;
    src_ready_d = OFF;
    io_inst_d   = io_inst_q;
    io_din_d    = io_din_q;
    busy_d      = busy_q;
    done_d      = OFF;
    err_d       = OFF;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!range_ok) begin
            err_d = ON;
          end else begin
            addr_d      = base_addr;
            cnt_d       = word_cnt;
            loaded_d    = '0;
            aborted_d   = OFF;
            busy_d      = ON;
            interrupt_d = ON;
            io_inst_d   = '0;
            io_din_d    = '0;
            state_d     = ARM;
          end
        end
      end

      ARM: begin
        if (expired) begin
          if (abort) begin
            aborted_d = ON;
            io_inst_d = TERM_WORD[BIT_INST-1:0];
            state_d   = TERM;
          end else begin
            io_inst_d = load_cmd(addr_q);
            state_d   = SEL;
          end
        end
      end

      // The word is sampled on the edge where src_valid is seen; the
      // registered src_ready then marks that same word as consumed in the
      // following cycle, while the source is still holding it.
      SEL: begin
        if (expired) begin
          if (abort) begin
            aborted_d = ON;
            io_inst_d = TERM_WORD[BIT_INST-1:0];
            state_d   = TERM;
          end else if (bus.src_valid) begin
            src_ready_d = ON;
            io_din_d    = bus.src_data;
            state_d     = DATA;
          end
        end
      end

      DATA: begin
        if (expired) begin
          loaded_d = loaded_q + (AFW + 1)'(1);
          if (abort || (loaded_d == cnt_q)) begin
            aborted_d = aborted_q | abort;
            io_inst_d = TERM_WORD[BIT_INST-1:0];
            state_d   = TERM;
          end else begin
            addr_d    = addr_q + AFW'(1);
            io_inst_d = load_cmd(addr_d);
            state_d   = SEL;
          end
        end
      end

      TERM: begin
        if (expired) begin
          interrupt_d = OFF;
          io_inst_d   = '0;
          io_din_d    = '0;
          state_d     = REL;
        end
      end

      REL: begin
        if (expired) begin
          if (aborted_q) begin
            err_d = ON;
          end else begin
            done_d = ON;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = OFF;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.interrupt = interrupt_q;
  assign bus.src_ready = src_ready_q;
  assign bus.io_inst   = io_inst_q;
  assign bus.io_din    = io_din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign loaded        = loaded_q;

endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Autonomous master that programs the CPU instruction store over the CPU's existing interrupt/io_inst/io_din load protocol.
- Replaces hand-sequenced bench stimulus with a reusable block.
- Takes program words from a valid/ready source, such as a boot ROM reader or debug UART, and sequences load-address and load-data phases for each word.
- Ends with the terminate word and releases interrupt.
- Generalised in instruction/data width, store depth, phase hold time, base address and word count; adds stall, abort and range-error handling.

Parameters:
- BIT_INST, 16, io_inst width.
- BIT_DATA, 16, io_din and source word width.
- SZA_INS, 16, instruction store depth in words; power of two, at least 2.
- OPC_W, 4, opcode field width at the top of io_inst.
- LD_OPC, 4'hE, load-instruction opcode value; must match the CPU's LD_INS.
- HOLD, 4, clock cycles each phase is held stable; at least 1.
- AFW, clog2(SZA_INS), address field width (derived); requires OPC_W + AFW ≤ BIT_INST.

Ports:
- clock, in, 1, system clock; all state updates on rising edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request; sampled only in IDLE.
- abort, in, 1, level; terminates load at the next phase boundary.
- base_addr, in, AFW, first store address; sampled with start.
- word_cnt, in, AFW+1, number of words to load, 1..SZA_INS; sampled with start.
- src_valid, in, 1, source word available.
- src_data, in, BIT_DATA, source program word.
- src_ready, out, 1, word consumed this cycle.
- interrupt, out, 1, CPU load-mode request.
- io_inst, out, BIT_INST, load command to CPU.
- io_din, out, BIT_DATA, instruction word to CPU.
- busy, out, 1, high from accepted start until DONE exits.
- done, out, 1, one-cycle pulse on successful completion.
- err, out, 1, one-cycle pulse on range error or abort.
- loaded, out, AFW+1, count of words fully loaded in current or last run.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; interrupt, src_ready, busy, done and err = 0; io_inst, io_din and loaded = 0; hold counter = 0.
- Encoding: the load command is {LD_OPC, addr[AFW-1:0], zeros}. The terminate word is all ones.
- IDLE:
  - On start, if word_cnt = 0 or base_addr + word_cnt > SZA_INS: pulse err next cycle and stay IDLE. No bus activity.
  - Otherwise latch base_addr and word_cnt, clear loaded, set busy, go to ARM.
- ARM: drive interrupt = 1 and keep buses at 0 for HOLD cycles, then go to SEL.
- SEL: drive io_inst = command for the current address. The address starts at base_addr and increments by 1 per word; it never wraps because range is pre-checked.
  - Hold at least HOLD cycles.
  - After the hold, wait for src_valid. Stay in SEL with io_inst stable while src_valid = 0.
  - When src_valid = 1, assert src_ready for exactly that cycle, latch src_data into io_din, and go to DATA.
- DATA: io_din is held for HOLD cycles; io_inst is unchanged. Then increment loaded.
  - If loaded equals word_cnt, go to TERM.
  - Otherwise, advance the address and go to SEL.
- TERM: io_inst = all ones for HOLD cycles, then go to REL.
- REL: interrupt = 0, io_inst = 0, io_din = 0 for HOLD cycles, then go to DONE.
- DONE: pulse done for one cycle, then go to IDLE with busy = 0.
- Abort:
  - Sampled only at phase boundaries, i.e. when the hold counter expires or in the SEL wait.
  - In ARM, SEL or DATA, abort diverts to TERM. The current DATA phase completes first and counts in loaded.
  - Exit after an abort goes via TERM and REL to an err pulse instead of done.
  - Abort in TERM or REL is ignored.
- start while busy is ignored.
- Hold counter: width clog2(HOLD+1). It reloads on every state entry, and all outputs are registered.
- Invariant: at most one src_ready per word; no word is consumed in any state except SEL.
- Latency with an always-valid source: 1 + HOLD·(2·word_cnt + 3) + 1 cycles from start to the done pulse.

Decomposition:
- Shared definitions file:
  - LD_OPC default (same value as the CPU's LD_INS).
  - State encodings IDLE/ARM/SEL/DATA/TERM/REL/DONE.
  - Terminate-word constant.
  - ON/OFF.
- Single sub-module phase_timer: a loadable down-counter with an expire flag, instantiated once.

Test Plan:
- Reset then start, base 0, cnt 8, HOLD 4, always-valid source with words W0..W7:
  - Expect 8 SEL/DATA pairs with io_inst = {LD_OPC, 0..7, 0}, each held exactly 4 cycles.
  - Expect TERM all-ones, then interrupt low, done pulsed at cycle 1+4·19+1 = 78, loaded = 8.
- base 14, cnt 3 with SZA_INS 16 -> err pulse one cycle after start; interrupt never rises; busy stays 0.
- base 5, cnt 2; src_valid low for 10 cycles after the first SEL hold -> io_inst stays {LD_OPC, 5, 0}, src_ready stays 0 until valid; exactly 2 src_ready pulses in total.
- cnt 4; abort asserted during the second DATA phase -> that word completes, TERM and REL follow, err pulses, done does not, loaded = 2.
- reset driven low mid-DATA -> all outputs 0 immediately (asynchronous); after release, a new start, base 0, cnt 1, completes normally.
- base 15, cnt 1 (top address) and base 0, cnt 16 (full depth) -> both complete with done; last io_inst address is 15.
